// File: rtl/cc_unit.sv
// Execute-stage ALU with registered result and condition codes (CF = {SF, ZF, OF}).
// All outputs come straight from flops; the only combinational logic feeds the registers.
module cc_unit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       ifun,
    input  logic [WIDTH-1:0] aluA,
    input  logic [WIDTH-1:0] aluB,
    input  logic             set_cc,
    input  logic             inhibit,
    input  logic             stall,
    output logic             out_valid,
    output logic [WIDTH-1:0] valE,
    output logic             out_err,
    output logic [2:0]       CF
);

    // Handshake: an op on the inputs is taken on any rising edge where in_valid=1 and
    // stall=0 (stall is the inverse of ready). out_valid=1 marks valE/out_err as the
    // result of the op accepted on the previous unstalled edge; there is no output-side
    // backpressure other than stall, which freezes every register.
    logic             accept;
    logic [WIDTH-1:0] res;
    logic             of;
    logic             zf;
    logic             sf;
    logic             err;
    logic             cc_we;

    assign accept = in_valid && !stall;

    always_comb begin
        res = '0;
        of  = 1'b0;
        err = 1'b0;
        case (ifun)
            4'd0: begin
                res = aluB + aluA;
                of  = (aluA[WIDTH-1] == aluB[WIDTH-1]) && (res[WIDTH-1] != aluA[WIDTH-1]);
            end
            4'd1: begin
                res = aluB - aluA;
                of  = (aluA[WIDTH-1] != aluB[WIDTH-1]) && (res[WIDTH-1] != aluB[WIDTH-1]);
            end
            4'd2:    res = aluB & aluA;
            4'd3:    res = aluB ^ aluA;
            default: err = 1'b1;
        endcase
    end

    assign zf = (res == '0);
    assign sf = res[WIDTH-1];

    // Illegal functions and downstream exceptions must never disturb the flags.
    assign cc_we = accept && set_cc && !inhibit && !err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            valE      <= '0;
            out_err   <= 1'b0;
            CF        <= 3'b010;
        end else if (!stall) begin
            out_valid <= in_valid;
            if (in_valid) begin
                valE    <= res;
                out_err <= err;
            end
            if (cc_we) begin
                CF <= {sf, zf, of};
            end
        end
    end

endmodule

// File: tb/tb_cc_unit.sv
// Directed bench for cc_unit: one task per scenario with hand-computed expectations.
module tb_cc_unit;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid;
    logic [3:0]   ifun;
    logic [W-1:0] aluA;
    logic [W-1:0] aluB;
    logic         set_cc;
    logic         inhibit;
    logic         stall;
    logic         out_valid;
    logic [W-1:0] valE;
    logic         out_err;
    logic [2:0]   CF;

    int checks = 0;
    int failures = 0;

    cc_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ifun(ifun),
        .aluA(aluA), .aluB(aluB), .set_cc(set_cc), .inhibit(inhibit),
        .stall(stall), .out_valid(out_valid), .valE(valE),
        .out_err(out_err), .CF(CF)
    );

    // clock/reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic drive(input logic iv, input logic [3:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic sc, input logic inh,
                         input logic st);
        in_valid = iv;
        ifun     = f;
        aluA     = a;
        aluB     = b;
        set_cc   = sc;
        inhibit  = inh;
        stall    = st;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 4'd0, '0, '0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (CF !== 3'b010) begin failures++; $display("FAIL reset_cf got=%b exp=010", CF); end
        checks++; if (valE !== 64'd0) begin failures++; $display("FAIL reset_vale got=%h exp=0", valE); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
        drive(1'b1, 4'd0, 64'd1, 64'd1, 1'b1, 1'b0, 1'b0);
        step();
        step();
        checks++; if (out_valid !== 1'b0 || CF !== 3'b010) begin failures++; $display("FAIL reset_held got=%b/%b exp=0/010", out_valid, CF); end
        drive(1'b0, 4'd0, '0, '0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || valE !== 64'd0) begin failures++; $display("FAIL reset_release got=%b/%h exp=0/0", out_valid, valE); end
    endtask

    task automatic test_add_overflow();
        drive(1'b1, 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (valE !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL add_ovf_vale got=%h exp=8000000000000000", valE); end
        checks++; if (CF !== 3'b101) begin failures++; $display("FAIL add_ovf_cf got=%b exp=101", CF); end
        checks++; if (out_valid !== 1'b1 || out_err !== 1'b0) begin failures++; $display("FAIL add_ovf_flags got=%b/%b exp=1/0", out_valid, out_err); end
    endtask

    task automatic test_sub_zero_no_cc();
        drive(1'b1, 4'd1, 64'd5, 64'd5, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (valE !== 64'd0) begin failures++; $display("FAIL sub_zero_vale got=%h exp=0", valE); end
        checks++; if (CF !== 3'b010) begin failures++; $display("FAIL sub_zero_cf got=%b exp=010", CF); end
        drive(1'b1, 4'd3, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        step();
        checks++; if (CF !== 3'b010) begin failures++; $display("FAIL xor_nocc_cf got=%b exp=010", CF); end
        drive(1'b1, 4'd3, 64'hF0, 64'h8000_0000_0000_000F, 1'b0, 1'b0, 1'b0);
        step();
        checks++; if (valE !== 64'h8000_0000_0000_00FF) begin failures++; $display("FAIL xor_nocc_vale got=%h exp=80000000000000ff", valE); end
        checks++; if (CF !== 3'b010) begin failures++; $display("FAIL xor_nocc_cf2 got=%b exp=010", CF); end
    endtask

    task automatic test_sub_overflow_inhibit();
        drive(1'b1, 4'd1, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (valE !== 64'h7FFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL sub_ovf_vale got=%h exp=7fffffffffffffff", valE); end
        checks++; if (CF !== 3'b001) begin failures++; $display("FAIL sub_ovf_cf got=%b exp=001", CF); end
        drive(1'b1, 4'd2, 64'hFF00, 64'h00FF, 1'b1, 1'b1, 1'b0);
        step();
        checks++; if (valE !== 64'd0 || out_valid !== 1'b1) begin failures++; $display("FAIL inhibit_and_vale got=%h/%b exp=0/1", valE, out_valid); end
        checks++; if (CF !== 3'b001) begin failures++; $display("FAIL inhibit_and_cf got=%b exp=001", CF); end
        drive(1'b1, 4'd1, 64'd5, 64'd5, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'd1, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0);
        step();
        checks++; if (valE !== 64'h7FFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL inhibit_sub_vale got=%h exp=7fffffffffffffff", valE); end
        checks++; if (CF !== 3'b010) begin failures++; $display("FAIL inhibit_sub_cf got=%b exp=010", CF); end
    endtask

    task automatic test_stall();
        drive(1'b1, 4'd0, 64'd2, 64'd3, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (valE !== 64'd5 || CF !== 3'b000) begin failures++; $display("FAIL stall_pre got=%h/%b exp=5/000", valE, CF); end
        drive(1'b1, 4'd1, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1);
        step();
        checks++; if (valE !== 64'd5 || out_valid !== 1'b1 || CF !== 3'b000) begin failures++; $display("FAIL stall_c1 got=%h/%b/%b exp=5/1/000", valE, out_valid, CF); end
        drive(1'b0, 4'd7, 64'd9, 64'd9, 1'b1, 1'b0, 1'b1);
        step();
        checks++; if (valE !== 64'd5 || out_valid !== 1'b1 || out_err !== 1'b0 || CF !== 3'b000) begin failures++; $display("FAIL stall_c2 got=%h/%b/%b/%b exp=5/1/0/000", valE, out_valid, out_err, CF); end
        drive(1'b1, 4'd7, 64'd4, 64'd4, 1'b1, 1'b1, 1'b1);
        step();
        checks++; if (valE !== 64'd5 || out_valid !== 1'b1 || out_err !== 1'b0 || CF !== 3'b000) begin failures++; $display("FAIL stall_c3 got=%h/%b/%b/%b exp=5/1/0/000", valE, out_valid, out_err, CF); end
        drive(1'b1, 4'd1, 64'd7, 64'd7, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (valE !== 64'd0 || CF !== 3'b010 || out_valid !== 1'b1) begin failures++; $display("FAIL stall_release got=%h/%b/%b exp=0/010/1", valE, CF, out_valid); end
    endtask

    task automatic test_idle();
        drive(1'b1, 4'd0, 64'd3, 64'd4, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 4'd1, 64'd9, 64'd1, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_out_valid got=%b exp=0", out_valid); end
        checks++; if (valE !== 64'd7 || CF !== 3'b000) begin failures++; $display("FAIL idle_hold got=%h/%b exp=7/000", valE, CF); end
    endtask

    task automatic test_bad_ifun();
        drive(1'b1, 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'd7, 64'd1, 64'd2, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (out_err !== 1'b1) begin failures++; $display("FAIL bad_ifun_err got=%b exp=1", out_err); end
        checks++; if (valE !== 64'd0) begin failures++; $display("FAIL bad_ifun_vale got=%h exp=0", valE); end
        checks++; if (CF !== 3'b101) begin failures++; $display("FAIL bad_ifun_cf got=%b exp=101", CF); end
        drive(1'b0, 4'd0, '0, '0, 1'b0, 1'b0, 1'b0);
        step();
        checks++; if (out_err !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bad_ifun_hold got=%b/%b exp=1/0", out_err, out_valid); end
        drive(1'b1, 4'd4, 64'd1, 64'd1, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (out_err !== 1'b1 || CF !== 3'b101) begin failures++; $display("FAIL ifun4 got=%b/%b exp=1/101", out_err, CF); end
        drive(1'b1, 4'd2, 64'h0F, 64'hFF, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (out_err !== 1'b0 || valE !== 64'h0F || CF !== 3'b000) begin failures++; $display("FAIL bad_ifun_recover got=%b/%h/%b exp=0/f/000", out_err, valE, CF); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (valE !== 64'hFFFF_FFFF_FFFF_FFFE || CF !== 3'b100) begin failures++; $display("FAIL b2b_0 got=%h/%b exp=fffffffffffffffe/100", valE, CF); end
        drive(1'b1, 4'd1, 64'd3, 64'd3, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (valE !== 64'd0 || CF !== 3'b010) begin failures++; $display("FAIL b2b_1 got=%h/%b exp=0/010", valE, CF); end
        drive(1'b1, 4'd2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (valE !== 64'h8000_0000_0000_0000 || CF !== 3'b100) begin failures++; $display("FAIL b2b_2 got=%h/%b exp=8000000000000000/100", valE, CF); end
        drive(1'b1, 4'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (valE !== 64'd0 || CF !== 3'b011 || out_valid !== 1'b1) begin failures++; $display("FAIL b2b_3 got=%h/%b/%b exp=0/011/1", valE, CF, out_valid); end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'd3, 64'h55, 64'hAA, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (CF !== 3'b010 || valE !== 64'd0 || out_valid !== 1'b0 || out_err !== 1'b0) begin failures++; $display("FAIL async_reset got=%b/%h/%b/%b exp=010/0/0/0", CF, valE, out_valid, out_err); end
        drive(1'b0, 4'd0, '0, '0, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || valE !== 64'd0 || CF !== 3'b010) begin failures++; $display("FAIL async_reset_first_edge got=%b/%h/%b exp=0/0/010", out_valid, valE, CF); end
        drive(1'b1, 4'd3, 64'h55, 64'hAA, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (valE !== 64'hFF || CF !== 3'b000 || out_valid !== 1'b1) begin failures++; $display("FAIL async_reset_resume got=%h/%b/%b exp=ff/000/1", valE, CF, out_valid); end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_zero_no_cc();
        test_sub_overflow_inhibit();
        test_stall();
        test_idle();
        test_bad_ifun();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cc_unit.md
CC_UNIT -- requirements
Module: cc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 64, datapath width in bits.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operation present on inputs this cycle.
REQ-005 SHALL have port ifun  input  4  OPq function: 0 add, 1 sub, 2 and, 3 xor.
REQ-006 SHALL have port aluA  input  WIDTH  operand A.
REQ-007 SHALL have port aluB  input  WIDTH  operand B.
REQ-008 SHALL have port set_cc  input  1  operation is permitted to update condition codes.
REQ-009 SHALL have port inhibit  input  1  exception downstream; blocks CC update only.
REQ-010 SHALL have port stall  input  1  freeze all registered state.
REQ-011 SHALL have port out_valid  output  1  valE/out_err registered and valid.
REQ-012 SHALL have port valE  output  WIDTH  registered ALU result.
REQ-013 SHALL have port out_err  output  1  registered flag: accepted op had ifun > 3.
REQ-014 SHALL have port CF  output  3  registered condition codes, CF[0]=OF, CF[1]=ZF, CF[2]=SF, for direct connection to the condition evaluator.

Function
REQ-015 SHALL accept an op on a rising edge when in_valid=1 and stall=0.
REQ-016 SHALL compute res = aluB+aluA (ifun 0), aluB-aluA (1), aluB&aluA (2), aluB^aluA (3), each modulo 2^WIDTH.
REQ-017 SHALL, for ifun > 3, use res=0, set out_err=1 for that op, and never update CF.
REQ-018 SHALL compute ZF = (res==0) and SF = res[WIDTH-1].
REQ-019 SHALL compute OF for add = sign(A)==sign(B) and sign(res)!=sign(A).
REQ-020 SHALL compute OF for sub = sign(A)!=sign(B) and sign(res)!=sign(B).
REQ-021 SHALL force OF=0 for and/xor.
REQ-022 SHALL register valE, out_err and out_valid=1 one cycle after acceptance (latency 1).
REQ-023 SHALL drive out_valid=0 after any clk edge with stall=0 and in_valid=0; valE and out_err then hold.
REQ-024 SHALL update CF on the same edge as valE only if the op is accepted, set_cc=1, inhibit=0 and ifun<=3; otherwise CF holds.
REQ-025 SHALL, when inhibit=1, still register valE/out_valid/out_err normally.
REQ-026 SHALL, when stall=1, hold valE, out_valid, out_err and CF regardless of all other inputs, including inhibit.
REQ-027 SHALL support back-to-back ops every cycle with no bubble; each CF update reflects only its own op.
REQ-028 SHALL have no combinational path from any input to any output.

Reset
REQ-029 SHALL, while rst_n=0, immediately and asynchronously force CF=3'b010 (ZF=1, SF=0, OF=0), valE=0, out_valid=0, out_err=0.
REQ-030 SHALL discard any in-flight op on reset; the first edge with rst_n=1 behaves as from idle.

Verification
REQ-031 SHALL pass: add A=1, B=0x7FFF_FFFF_FFFF_FFFF, set_cc=1 -> next cycle valE=0x8000_0000_0000_0000, CF=3'b101.
REQ-032 SHALL pass: sub A=5, B=5, set_cc=1 -> valE=0, CF=3'b010; then xor A=B=0 with set_cc=0 -> CF stays 3'b010.
REQ-033 SHALL pass: sub A=1, B=0x8000_0000_0000_0000 -> valE=0x7FFF_FFFF_FFFF_FFFF, CF=3'b001; same op with inhibit=1 -> valE updates, CF unchanged.
REQ-034 SHALL pass: stall=1 for 3 cycles with valid ops applied -> valE, out_valid, CF constant; first cycle after stall=0 accepts the op then present.
REQ-035 SHALL pass: ifun=7, in_valid=1, set_cc=1 -> out_err=1, valE=0, CF unchanged.
REQ-036 SHALL pass: rst_n pulsed low mid-clock during a stream -> outputs reach reset values before next edge, out_valid=0 on first edge if in_valid=0.
